ahb_lite_master: RTL

//  Single-outstanding AHB-Lite initiator: converts the multicycle core's

---
 rtl/ahb_lite_master.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: turns one core valid/ready request into
// one SINGLE transfer (NONSEQ address phase, waited data phase) and a one-cycle response.
module ahb_lite_master #(
  parameter int HANG_LIMIT = 1024,
  parameter int CNT_W      = 11
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        bus_hang,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_LERR} state_t;

  localparam logic [1:0]       TRANS_IDLE   = 2'b00;
  localparam logic [1:0]       TRANS_NONSEQ = 2'b10;
  localparam logic [CNT_W-1:0] HANG_MAX     = CNT_W'(HANG_LIMIT);
  localparam logic [CNT_W-1:0] HANG_PRE     = CNT_W'(HANG_LIMIT - 1);

  state_t            state, state_nxt;
  logic [31:0]       addr_q;
  logic              write_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              local_err;
  logic              accept;

  // Replicate the right-justified write value onto every byte lane it may occupy.
  function automatic logic [31:0] lane_rep(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'd0:    return {4{w[7:0]}};
      2'd1:    return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [1:0] sz, input logic [1:0] a,
                                               input logic [31:0] d);
    case (sz)
      2'd0:    return {24'd0, d[{a, 3'b000} +: 8]};
      2'd1:    return a[1] ? {16'd0, d[31:16]} : {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign local_err = (req_size == 2'd3) ||
                     (req_size == 2'd1 && req_addr[0]) ||
                     (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  assign accept    = (state == S_IDLE) && req_valid;

  assign HADDR     = addr_q;
  assign HWRITE    = write_q;
  assign HSIZE     = {1'b0, size_q};
  assign HWDATA    = wdata_q;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every output of this block is assigned a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    HTRANS    = TRANS_IDLE;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = local_err ? S_LERR : S_ADDR;
      end
      S_ADDR: begin
        HTRANS = TRANS_NONSEQ;
        if (HREADY) state_nxt = S_DATA;
      end
      S_DATA:  if (HREADY) state_nxt = S_IDLE;
      S_LERR:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= 2'd0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      bus_hang  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;

      if (accept) begin
        addr_q  <= req_addr;
        write_q <= req_write;
        size_q  <= req_size;
        wdata_q <= lane_rep(req_size, req_wdata);
        if (local_err) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end
      end

      if (state == S_ADDR && HREADY) wait_cnt <= '0;

      if (state == S_DATA) begin
        if (!HREADY) begin
          // Saturating count; the hang flag stays set until reset.
          if (wait_cnt != HANG_MAX) wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == HANG_PRE) bus_hang <= 1'b1;
        end else begin
          rsp_valid <= 1'b1;
          rsp_err   <= HRESP;
          rsp_rdata <= (write_q || HRESP) ? 32'd0 : lane_extract(size_q, addr_q[1:0], HRDATA);
        end
      end
    end
  end

endmodule
